// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the 5-stage RV32 core.
//
// Drives the ID-stage control mux (stall, id_flush), the PC and IF/ID
// enables, the IF flush, and a whole-pipeline freeze while data memory
// is busy. It also keeps saturating counters for load-use stalls and
// redirect events.
//
// Ports:
//   clk, rst_n                 core clock, async active-low reset
//   id_rs1/id_rs2, id_uses_*   source operands of the ID instruction
//   idex_mem_read, idex_rd     load in EX and its destination register
//   ex_redirect                taken branch / JAL / JALR resolved in EX
//   dmem_req, dmem_ready       data-memory handshake from MEM
//   stall, id_flush            to ID mux: bubble / squash ID instruction
//   if_flush                   clear IF/ID to NOP
//   pc_write, ifid_write       PC and IF/ID register enables
//   pipe_freeze                hold ID/EX, EX/MEM, MEM/WB
//   mem_err                    sticky memory-timeout flag
//   stall_count, flush_count   saturating performance counters
//
// state    | meaning
// RUN      | normal issue; redirect flush and load-use handled here
// MEM_WAIT | data memory busy; pipeline frozen until ready or timeout
module hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 255,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             idex_mem_read,
  input  logic [4:0]       idex_rd,
  input  logic             ex_redirect,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             stall,
  output logic             id_flush,
  output logic             if_flush,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             pipe_freeze,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [7:0] TIMEOUT      = 8'(MEM_TIMEOUT);

  state_t     state, state_nxt;
  logic [2:0] flush_cnt, flush_cnt_nxt;
  logic [7:0] wait_cnt, wait_cnt_nxt;
  logic       mem_err_nxt;
  logic       stall_inc, flush_inc;
  logic       lu;

  assign lu = idex_mem_read && (idex_rd != 5'd0) &&
              ((id_uses_rs1 && (id_rs1 == idex_rd)) ||
               (id_uses_rs2 && (id_rs2 == idex_rd)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      flush_cnt <= 3'd0;
      wait_cnt  <= 8'd0;
      mem_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
      wait_cnt  <= wait_cnt_nxt;
      mem_err   <= mem_err_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    wait_cnt_nxt  = wait_cnt;
    mem_err_nxt   = mem_err;
    stall_inc     = 1'b0;
    flush_inc     = 1'b0;
    stall         = 1'b0;
    id_flush      = 1'b0;
    if_flush      = 1'b0;
    pc_write      = 1'b0;
    ifid_write    = 1'b0;
    pipe_freeze   = 1'b0;

    case (state)
      RUN: begin
        if (dmem_req && !dmem_ready) begin
          pipe_freeze  = 1'b1;
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = 8'd1;
        end else if (ex_redirect) begin
          // A redirect squashes the ID instruction, so any load-use on it
          // is moot and is not counted as a stall.
          if_flush      = 1'b1;
          id_flush      = 1'b1;
          pc_write      = 1'b1;
          ifid_write    = 1'b1;
          flush_cnt_nxt = FLUSH_RELOAD;
          flush_inc     = 1'b1;
        end else if (flush_cnt != 3'd0) begin
          if_flush      = 1'b1;
          id_flush      = 1'b1;
          pc_write      = 1'b1;
          ifid_write    = 1'b1;
          flush_cnt_nxt = flush_cnt - 3'd1;
        end else if (lu) begin
          stall     = 1'b1;
          stall_inc = 1'b1;
        end else begin
          pc_write   = 1'b1;
          ifid_write = 1'b1;
        end
      end
      MEM_WAIT: begin
        // EX is frozen, so a pending redirect is simply seen again later;
        // flush_cnt holds its value across the wait.
        pipe_freeze = !dmem_ready;
        pc_write    = dmem_ready;
        ifid_write  = dmem_ready;
        if (dmem_ready) begin
          state_nxt = RUN;
        end else if (wait_cnt == TIMEOUT) begin
          mem_err_nxt = 1'b1;
          state_nxt   = RUN;
        end else begin
          wait_cnt_nxt = wait_cnt + 8'd1;
        end
      end
      default: state_nxt = RUN;
    endcase

    // Outputs are combinational, so they must be forced quiet while reset
    // is held, not just from the next edge onward.
    if (!rst_n) begin
      stall       = 1'b0;
      id_flush    = 1'b0;
      if_flush    = 1'b0;
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      pipe_freeze = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall_inc && (stall_count != '1)) stall_count <= stall_count + 1'b1;
      if (flush_inc && (flush_count != '1)) flush_count <= flush_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  id_rs1, id_rs2, idex_rd;
  logic        id_uses_rs1, id_uses_rs2, idex_mem_read;
  logic        ex_redirect, dmem_req, dmem_ready;
  logic        stall, id_flush, if_flush, pc_write, ifid_write, pipe_freeze, mem_err;
  logic [15:0] stall_count, flush_count;

  always #5 clk = ~clk;

  hazard_ctrl #(.FLUSH_CYCLES(3), .MEM_TIMEOUT(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .idex_mem_read(idex_mem_read), .idex_rd(idex_rd),
    .ex_redirect(ex_redirect), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .stall(stall), .id_flush(id_flush), .if_flush(if_flush),
    .pc_write(pc_write), .ifid_write(ifid_write), .pipe_freeze(pipe_freeze),
    .mem_err(mem_err), .stall_count(stall_count), .flush_count(flush_count)
  );

  // flags = {stall, id_flush, if_flush, pc_write, ifid_write, pipe_freeze, mem_err}
  typedef struct {
    string       name;
    logic [6:0]  flags;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [6:0] IDLE   = 7'b0001100;
  localparam logic [6:0] STALL  = 7'b1000000;
  localparam logic [6:0] FLUSH  = 7'b0111100;
  localparam logic [6:0] FREEZE = 7'b0000010;
  localparam logic [6:0] QUIET  = 7'b0000000;

  // Monitor: outputs are combinational, so every cycle presents a result;
  // sample mid-cycle and compare against whatever the driver queued.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [6:0] act;
      e = exp_q.pop_front();
      act = {stall, id_flush, if_flush, pc_write, ifid_write, pipe_freeze, mem_err};
      checks++;
      if (act !== e.flags || stall_count !== e.sc || flush_count !== e.fc) begin
        errors++;
        $display("FAIL %s: got flags=%b sc=%0d fc=%0d, want flags=%b sc=%0d fc=%0d",
                 e.name, act, stall_count, flush_count, e.flags, e.sc, e.fc);
      end
    end
  end

  task automatic expect_now(input string name, input logic [6:0] flags,
                            input int sc, input int fc);
    exp_t e;
    e.name = name; e.flags = flags; e.sc = 16'(sc); e.fc = 16'(fc);
    exp_q.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; idex_rd = 5'd0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; idex_mem_read = 1'b0;
    ex_redirect = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic set_lu(input logic on);
    idex_mem_read = on; idex_rd = 5'd5; id_uses_rs1 = on; id_rs1 = 5'd5;
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    #1;
    expect_now("reset", QUIET, 0, 0);
    next_cycle(); next_cycle();
    rst_n = 1'b1;

    expect_now("idle", IDLE, 0, 0); next_cycle();

    // load-use on rs1
    set_lu(1'b1);
    expect_now("lu_rs1", STALL, 0, 0); next_cycle();
    clear_inputs();
    expect_now("after_lu", IDLE, 1, 0); next_cycle();
    // rd = x0 never stalls
    idex_mem_read = 1'b1; idex_rd = 5'd0; id_uses_rs1 = 1'b1; id_rs1 = 5'd0;
    expect_now("lu_x0", IDLE, 1, 0); next_cycle();
    // rs2 match
    clear_inputs();
    idex_mem_read = 1'b1; idex_rd = 5'd7; id_uses_rs2 = 1'b1; id_rs2 = 5'd7;
    expect_now("lu_rs2", STALL, 1, 0); next_cycle();
    // same match but not a load
    idex_mem_read = 1'b0;
    expect_now("no_load", IDLE, 2, 0); next_cycle();
    clear_inputs();

    // single redirect: three flush cycles
    ex_redirect = 1'b1;
    expect_now("redir_c1", FLUSH, 2, 0); next_cycle();
    ex_redirect = 1'b0;
    expect_now("redir_c2", FLUSH, 2, 1); next_cycle();
    expect_now("redir_c3", FLUSH, 2, 1); next_cycle();
    expect_now("redir_end", IDLE, 2, 1); next_cycle();

    // second pulse on cycle 2 restarts the window
    ex_redirect = 1'b1;
    expect_now("re2_c1", FLUSH, 2, 1); next_cycle();
    expect_now("re2_c2", FLUSH, 2, 2); next_cycle();
    ex_redirect = 1'b0;
    expect_now("re2_c3", FLUSH, 2, 3); next_cycle();
    expect_now("re2_c4", FLUSH, 2, 3); next_cycle();
    expect_now("re2_end", IDLE, 2, 3); next_cycle();

    // redirect + lu together: flush only, lu suppressed during flush window
    ex_redirect = 1'b1; set_lu(1'b1);
    expect_now("redir_lu", FLUSH, 2, 3); next_cycle();
    ex_redirect = 1'b0;
    expect_now("flush_lu1", FLUSH, 2, 4); next_cycle();
    expect_now("flush_lu2", FLUSH, 2, 4); next_cycle();
    expect_now("lu_after_flush", STALL, 2, 4); next_cycle();
    clear_inputs();
    expect_now("idle2", IDLE, 3, 4); next_cycle();

    // memory wait: 4 not-ready cycles then ready
    dmem_req = 1'b1; dmem_ready = 1'b0;
    expect_now("mw_c1", FREEZE, 3, 4); next_cycle();
    expect_now("mw_c2", FREEZE, 3, 4); next_cycle();
    expect_now("mw_c3", FREEZE, 3, 4); next_cycle();
    expect_now("mw_c4", FREEZE, 3, 4); next_cycle();
    dmem_ready = 1'b1;
    expect_now("mw_ready", IDLE, 3, 4); next_cycle();
    clear_inputs();
    expect_now("mw_after", IDLE, 3, 4); next_cycle();

    // freeze in the middle of a flush window pauses it
    ex_redirect = 1'b1;
    expect_now("mf_redir", FLUSH, 3, 4); next_cycle();
    ex_redirect = 1'b0; dmem_req = 1'b1;
    expect_now("mf_frz1", FREEZE, 3, 5); next_cycle();
    ex_redirect = 1'b1;  // ignored while waiting
    expect_now("mf_frz2", FREEZE, 3, 5); next_cycle();
    ex_redirect = 1'b0; dmem_ready = 1'b1;
    expect_now("mf_ready", IDLE, 3, 5); next_cycle();
    clear_inputs();
    expect_now("mf_rest1", FLUSH, 3, 5); next_cycle();
    expect_now("mf_rest2", FLUSH, 3, 5); next_cycle();
    expect_now("mf_end", IDLE, 3, 5); next_cycle();

    // timeout after 4 MEM_WAIT cycles
    dmem_req = 1'b1; dmem_ready = 1'b0;
    expect_now("to_run", FREEZE, 3, 5); next_cycle();
    for (int i = 1; i <= 4; i++) begin
      expect_now($sformatf("to_wait%0d", i), FREEZE, 3, 5); next_cycle();
    end
    dmem_req = 1'b0;
    expect_now("to_err", IDLE | 7'b0000001, 3, 5); next_cycle();
    expect_now("to_sticky", IDLE | 7'b0000001, 3, 5); next_cycle();

    // async reset asserted mid MEM_WAIT, checked before the next edge
    dmem_req = 1'b1;
    expect_now("pre_rst_frz", FREEZE | 7'b0000001, 3, 5); next_cycle();
    expect_now("pre_rst_wait", FREEZE | 7'b0000001, 3, 5); next_cycle();
    rst_n = 1'b0;
    expect_now("async_rst", QUIET, 0, 0); next_cycle();
    clear_inputs();
    rst_n = 1'b1;
    expect_now("post_rst", IDLE, 0, 0); next_cycle();

    // stall counter saturation
    set_lu(1'b1);
    repeat (70000) next_cycle();
    clear_inputs();
    expect_now("sat", IDLE, 65535, 0); next_cycle();

    next_cycle();
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
